// File: rtl/led_level_meter.sv
// LED bar-graph level meter on the PacoBlaze output port map.
// Takes a sign-plus-magnitude level byte and drives a sign LED plus a bar in
// one of four display modes. A peak tracker holds the highest recent level
// and then lets it fall one LED at a time. A sample-arrival interrupt flags
// overruns.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | peak equals the displayed level and follows it downward
// ST_HOLD | a fresh peak is frozen while hold_cnt_q runs down
// ST_DECAY| peak drops one LED each time decay_cnt_q expires
module led_level_meter #(
    parameter int           NUM_LEDS         = 10,
    parameter logic [7:0]   LEVEL_PORT       = 8'h80,
    parameter logic [7:0]   STATUS_PORT      = 8'h81,
    parameter int           PEAK_HOLD_CYCLES = 12500000,
    parameter int           DECAY_CYCLES     = 2500000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  port_id,
    input  logic [7:0]                  out_port,
    input  logic                        write_strobe,
    input  logic [1:0]                  mode,
    input  logic                        new_sample,
    input  logic                        irq_ack,
    output logic [NUM_LEDS-1:0]         led,
    output logic                        irq,
    output logic                        irq_overrun,
    output logic [$clog2(NUM_LEDS)-1:0] peak_level
);

    localparam int NUM_BAR = NUM_LEDS - 1;
    localparam int LW      = $clog2(NUM_LEDS);
    localparam int HW      = (PEAK_HOLD_CYCLES > 1) ? $clog2(PEAK_HOLD_CYCLES) : 1;
    localparam int DW      = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;

    localparam logic [HW-1:0] HOLD_INIT  = HW'(PEAK_HOLD_CYCLES - 1);
    localparam logic [DW-1:0] DECAY_INIT = DW'(DECAY_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
    localparam logic [DW-1:0] DECAY_ONE  = DW'(1);
    localparam logic [LW-1:0] PEAK_ONE   = LW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DECAY = 2'd2
    } state_t;

    state_t              state_q;
    logic [LW-1:0]       level_q;
    logic [LW-1:0]       level_d;
    logic [LW-1:0]       peak_q;
    logic                sign_q;
    logic [7:0]          raw_q;
    logic [HW-1:0]       hold_cnt_q;
    logic [DW-1:0]       decay_cnt_q;
    logic [NUM_LEDS-1:0] led_q;
    logic [NUM_LEDS-1:0] led_d;
    logic                irq_q;
    logic                irq_d;
    logic                ovr_q;
    logic                ovr_d;
    logic                lvl_wr;
    logic                stat_wr;
    logic [NUM_BAR-1:0]  bar_up;
    logic [NUM_BAR-1:0]  bar_dn;
    logic [NUM_BAR-1:0]  dot;
    logic [NUM_LEDS-1:0] raw_ext;

    assign lvl_wr  = write_strobe && (port_id == LEVEL_PORT);
    assign stat_wr = write_strobe && (port_id == STATUS_PORT);

    // Saturate the 7-bit magnitude to the bar length.
    always_comb begin
        level_d = level_q;
        if (lvl_wr) begin
            if (int'(out_port[7:1]) > NUM_BAR)
                level_d = LW'(NUM_BAR);
            else
                level_d = LW'(out_port[7:1]);
        end
    end

    // Level register and peak tracker; a write at or above the peak always restarts the hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            level_q     <= '0;
            peak_q      <= '0;
            sign_q      <= 1'b0;
            raw_q       <= '0;
            hold_cnt_q  <= '0;
            decay_cnt_q <= '0;
        end else begin
            if (lvl_wr) begin
                level_q <= level_d;
                sign_q  <= out_port[0];
                raw_q   <= out_port;
            end
            if (lvl_wr && (level_d >= peak_q)) begin
                peak_q     <= level_d;
                hold_cnt_q <= HOLD_INIT;
                state_q    <= ST_HOLD;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // Nothing is being held, so a lower level pulls the peak straight down.
                        if (lvl_wr)
                            peak_q <= level_d;
                    end
                    ST_HOLD: begin
                        if (hold_cnt_q == '0) begin
                            state_q     <= ST_DECAY;
                            decay_cnt_q <= DECAY_INIT;
                        end else begin
                            hold_cnt_q <= hold_cnt_q - HOLD_ONE;
                        end
                    end
                    ST_DECAY: begin
                        if (decay_cnt_q == '0) begin
                            if (peak_q > level_q) begin
                                peak_q      <= peak_q - PEAK_ONE;
                                decay_cnt_q <= DECAY_INIT;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            decay_cnt_q <= decay_cnt_q - DECAY_ONE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Build the LED image for the selected mode from the registered state.
    always_comb begin
        bar_up  = '0;
        bar_dn  = '0;
        dot     = '0;
        raw_ext = '0;
        for (int i = 0; i < NUM_BAR; i++) begin
            bar_up[i] = (i < int'(level_q));
            bar_dn[i] = (i >= NUM_BAR - int'(level_q));
            dot[i]    = (peak_q != '0) && (i == int'(peak_q) - 1);
        end
        for (int i = 0; i < NUM_LEDS && i < 8; i++)
            raw_ext[i] = raw_q[i];
        case (mode)
            2'd0:    led_d = {sign_q, bar_up};
            2'd1:    led_d = {bar_dn, sign_q};
            2'd2:    led_d = {sign_q, bar_up | dot};
            default: led_d = raw_ext;
        endcase
    end

    // Register the LED drive.
    always_ff @(posedge clk) begin
        if (reset)
            led_q <= '0;
        else
            led_q <= led_d;
    end

    // Interrupt next state: a new sample wins over an ack, and an overrun set wins over a clear.
    always_comb begin
        irq_d = new_sample | (irq_q & ~irq_ack);
        ovr_d = ovr_q;
        if (new_sample && irq_q && !irq_ack)
            ovr_d = 1'b1;
        else if (stat_wr)
            ovr_d = 1'b0;
    end

    // Register the interrupt request and the sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
            ovr_q <= ovr_d;
        end
    end

    assign led         = led_q;
    assign irq         = irq_q;
    assign irq_overrun = ovr_q;
    assign peak_level  = peak_q;

endmodule

// File: doc/led_level_meter.md
# led_level_meter

Parametrised LED bar-graph level meter for the PacoBlaze I/O map. It succeeds the fixed 10-LED, 3-bit bar decoder. It accepts a sign-plus-magnitude level byte written by the processor on a decoded output port and drives a configurable-width LED bank in one of four display modes. It adds peak-hold with timed decay, which the previous decoder did not have, and a sample-arrival interrupt request with overrun detection.

## Interface

Parameters:
- NUM_LEDS, 10: total LEDs, minimum 3. Bar length NUM_BAR = NUM_LEDS-1; the remaining LED shows the sign.
- LEVEL_PORT, 8'h80: port_id value selecting the level register. Decoding uses a full 8-bit compare.
- STATUS_PORT, 8'h81: writing to this port clears irq_overrun.
- PEAK_HOLD_CYCLES, 12500000: number of cycles a new peak is held before decay starts (500 ms at 25 MHz).
- DECAY_CYCLES, 2500000: cycles per one-LED peak decrement.

Ports:
- clk, input, 1: the single clock.
- reset, input, 1: synchronous, active-high.
- port_id, input, 8: processor port address.
- out_port, input, 8: processor write data.
- write_strobe, input, 1: one-cycle write qualifier.
- mode, input, 2: display mode, taken from the board switches.
- new_sample, input, 1: one-cycle pulse marking that a new sample is available.
- irq_ack, input, 1: processor interrupt_ack.
- led, output, NUM_LEDS: registered LED drive.
- irq, output, 1: interrupt request, level-held until acknowledged.
- irq_overrun, output, 1: sticky flag; a sample arrived while irq was still pending.
- peak_level, output, clog2(NUM_LEDS): current peak, available for readback.

## Operation

Level write:
- Triggered when write_strobe && port_id==LEVEL_PORT.
- sign <= out_port[0].
- level <= min(out_port[7:1], NUM_BAR), i.e. saturated to the bar length.
- raw <= out_port.

Peak tracker:
- A registered write with level >= peak sets peak <= level, reloads hold_cnt to PEAK_HOLD_CYCLES-1, and enters HOLD.
- HOLD state: hold_cnt decrements each cycle. At 0, go to DECAY with decay_cnt = DECAY_CYCLES-1.
- DECAY state: decay_cnt counts down to 0. At 0, if peak > level then peak decrements by 1 and decay_cnt reloads; otherwise go to IDLE.
- IDLE state: peak == level.
- A level write with value >= peak from any state restarts HOLD.
- A level write below peak does not alter the state.

Display modes (the LED image is computed from the registered level/peak/sign/raw):
- Mode 0, bar-up: led[NUM_LEDS-1] = sign; led[level-1:0] = 1; all other bar LEDs 0.
- Mode 1, bar-down: led[0] = sign; the top `level` LEDs of led[NUM_LEDS-1:1] are 1.
- Mode 2, bar + peak dot: same as mode 0, plus led[peak-1] = 1 when peak > 0.
- Mode 3, raw: led[7:0] = raw (truncated if NUM_LEDS < 8); upper bits 0.
- A mode change takes effect on the next LED update without disturbing the tracker.

Interrupt:
- A new_sample pulse sets irq.
- irq_ack clears irq.
- If new_sample and irq_ack occur in the same cycle, irq stays 1, so no event is lost.
- A new_sample pulse while irq==1 and irq_ack==0 sets irq_overrun.
- irq_overrun is cleared by reset or by a write to STATUS_PORT. If that clear coincides with a new overrun, the set wins.

Reset (synchronous, highest priority):
- led = 0, irq = 0, irq_overrun = 0, peak_level = 0.
- level, sign, raw, hold_cnt and decay_cnt all 0; tracker in IDLE.

## Timing

- A write strobe in cycle N updates level/sign/raw/peak at the edge ending N; led reflects the write at the edge ending N+1 (2-cycle write-to-LED latency).
- new_sample in cycle N produces irq=1 at N+1. irq_ack in cycle M produces irq=0 at M+1.
- A peak set at edge E holds for exactly PEAK_HOLD_CYCLES cycles. The first decrement occurs PEAK_HOLD_CYCLES+DECAY_CYCLES cycles after E; later decrements follow every DECAY_CYCLES cycles.
- Counter widths are clog2(param). Counters must not wrap: each reloads only on state entry or on a decrement.
- Writes to any other port_id, or with write_strobe low, have no effect.
- Reset asserted mid-HOLD or mid-DECAY returns every output to its reset value on the next edge.

## Test plan

Parameters for all scenarios: NUM_LEDS=10, PEAK_HOLD_CYCLES=8, DECAY_CYCLES=4.

1. Reset, then mode 0, write 8'h0B to 8'h80 (sign=1, level=5) → two cycles later led=10'b1000011111; peak_level=5.
2. Write 8'hFE (level 127) → level saturates to 9 → led=10'b0111111111. Switch to mode 1 → led=10'b1111111110.
3. Mode 2: write 8'h0E (level 7), then 8'h04 (level 2) → led=10'b0001000011. The peak dot stays 8 cycles, then moves down one LED every 4 cycles, reaching the bar with led=10'b0000000011 and returning to IDLE.
4. Write 8'h06 (level 3) while in DECAY at peak 5 → peak stays 5; then write 8'h0C (level 6) → peak=6 and the HOLD count restarts.
5. new_sample with irq_ack low → irq=1 next cycle. A second new_sample → irq_overrun=1. new_sample and irq_ack in the same cycle → irq stays 1. Write to 8'h81 → irq_overrun=0.
6. Mode 3 with a write of 8'hA5 → led=10'b0010100101. Writes to 8'h40 leave led unchanged. Asserting reset mid-HOLD → led=0, irq=0, peak_level=0 next cycle.
